// File: rtl/ieeedrv_sd_resp_if.sv
// SD block-transfer bus between a drive (master) and the image-store responder (slave).
// Signal suffixes are given from the responder's point of view.
interface ieeedrv_sd_resp_if #(
  parameter int SUBDRV = 2
);
  logic [SUBDRV-1:0]        img_mounted_i;
  logic [SUBDRV-1:0]        img_readonly_i;
  logic [SUBDRV-1:0][31:0]  img_size_i;
  logic [SUBDRV-1:0][31:0]  sd_lba_i;
  logic [SUBDRV-1:0][5:0]   sd_blk_cnt_i;
  logic [SUBDRV-1:0]        sd_rd_i;
  logic [SUBDRV-1:0]        sd_wr_i;
  logic [SUBDRV-1:0][7:0]   sd_buff_din_i;
  logic [SUBDRV-1:0]        sd_ack_o;
  logic [12:0]              sd_buff_addr_o;
  logic [7:0]               sd_buff_dout_o;
  logic                     sd_buff_wr_o;

  modport master (
    output img_mounted_i, img_readonly_i, img_size_i, sd_lba_i, sd_blk_cnt_i,
           sd_rd_i, sd_wr_i, sd_buff_din_i,
    input  sd_ack_o, sd_buff_addr_o, sd_buff_dout_o, sd_buff_wr_o
  );

  modport slave (
    input  img_mounted_i, img_readonly_i, img_size_i, sd_lba_i, sd_blk_cnt_i,
           sd_rd_i, sd_wr_i, sd_buff_din_i,
    output sd_ack_o, sd_buff_addr_o, sd_buff_dout_o, sd_buff_wr_o
  );
endinterface

// File: rtl/ieeedrv_sd_resp.sv
// Image-store responder for the drive-side SD block interface; moves 256-byte blocks to/from a byte memory port.
// Optional IEEEDRV_SDRESP_RANGE_EN: bytes beyond img_size read as zero / are dropped, flagged on range_err_o.
//
// state       | meaning
// S_IDLE      | wait for an armed, mounted request
// S_START     | raise ack, issue first access
// S_RD_REQ    | memory read outstanding
// S_RD_PUT    | one-cycle sd_buff_wr strobe of a read byte
// S_WR_ADDR   | present buffer address to the drive
// S_WR_WAIT   | drive buffer read latency
// S_WR_SAMPLE | capture drive data, start memory write
// S_WR_REQ    | memory write outstanding
// S_DONE      | drop ack, return to idle
module ieeedrv_sd_resp #(
  parameter int  SUBDRV = 2,
  localparam int DW     = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  ieeedrv_sd_resp_if.slave sd,
  output logic [DW-1:0]    mem_drv_o,
  output logic [31:0]      mem_addr_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic [7:0]       mem_wdata_o,
  input  logic [7:0]       mem_rdata_i,
  input  logic             mem_ready_i,
  output logic             busy_o,
  output logic             range_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_RD_REQ, S_RD_PUT, S_WR_ADDR, S_WR_WAIT, S_WR_SAMPLE, S_WR_REQ, S_DONE
  } state_t;

  state_t              state_q;
  logic [DW-1:0]       drv_q;
  logic                dir_wr_q, ro_q;
  logic [23:0]         lba_q;
  logic [13:0]         last_q, offset_q;
  logic [SUBDRV-1:0]   armed_q, ack_q;
  logic [12:0]         buff_addr_q;
  logic [7:0]          buff_dout_q, wdata_q;
  logic                buff_wr_q, mem_rd_q, mem_wr_q, range_err_q;
  logic [31:0]         mem_addr_q;
`ifdef IEEEDRV_SDRESP_RANGE_EN
  logic [31:0]         size_q;
`endif

  logic [SUBDRV-1:0]   req_d, pending_d;
  logic                grant_vld_d, grant_wr_d;
  logic [DW-1:0]       grant_drv_d;
  logic [13:0]         off_nxt_d;
  logic [31:0]         base_d, cur_addr_d, nxt_addr_d;
  logic                cur_oor_d, nxt_oor_d, is_last_d, abort_d;

  always_comb begin
    req_d       = sd.sd_rd_i | sd.sd_wr_i;
    pending_d   = req_d & sd.img_mounted_i & armed_q;
    grant_vld_d = 1'b0;
    grant_wr_d  = 1'b0;
    grant_drv_d = '0;
    // descending scan so the lowest pending index is the one that sticks
    for (int i = SUBDRV - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        grant_vld_d = 1'b1;
        grant_drv_d = DW'(i);
        grant_wr_d  = ~sd.sd_rd_i[i];
      end
    end
    off_nxt_d  = (state_q == S_START) ? 14'd0 : offset_q + 14'd1;
    base_d     = {lba_q, 8'h00};
    cur_addr_d = base_d + {18'd0, offset_q};
    nxt_addr_d = base_d + {18'd0, off_nxt_d};
`ifdef IEEEDRV_SDRESP_RANGE_EN
    cur_oor_d  = (cur_addr_d >= size_q);
    nxt_oor_d  = (nxt_addr_d >= size_q);
`else
    cur_oor_d  = 1'b0;
    nxt_oor_d  = 1'b0;
`endif
    is_last_d  = (offset_q == last_q);
    abort_d    = (state_q != S_IDLE) && (state_q != S_DONE) && !sd.img_mounted_i[drv_q];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drv_q       <= '0;
      dir_wr_q    <= 1'b0;
      ro_q        <= 1'b0;
      lba_q       <= '0;
      last_q      <= '0;
      offset_q    <= '0;
      armed_q     <= '1;
      ack_q       <= '0;
      buff_addr_q <= '0;
      buff_dout_q <= '0;
      buff_wr_q   <= 1'b0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      range_err_q <= 1'b0;
`ifdef IEEEDRV_SDRESP_RANGE_EN
      size_q      <= '0;
`endif
    end else begin
      armed_q <= armed_q | ~req_d;
      case (state_q)
        S_IDLE: if (grant_vld_d) begin
          drv_q    <= grant_drv_d;
          dir_wr_q <= grant_wr_d;
          ro_q     <= sd.img_readonly_i[grant_drv_d];
          lba_q    <= sd.sd_lba_i[grant_drv_d][23:0];
          last_q   <= {sd.sd_blk_cnt_i[grant_drv_d], 8'hFF};
`ifdef IEEEDRV_SDRESP_RANGE_EN
          size_q   <= sd.img_size_i[grant_drv_d];
`endif
          armed_q[grant_drv_d] <= 1'b0;
          state_q  <= S_START;
        end
        // START and RD_PUT share the "issue next read byte" path
        S_START, S_RD_PUT: begin
          buff_wr_q <= 1'b0;
          offset_q  <= off_nxt_d;
          if (state_q == S_START) ack_q <= SUBDRV'(1) << drv_q;
          if (state_q == S_RD_PUT && is_last_d) begin
            state_q <= S_DONE;
          end else if (state_q == S_START && dir_wr_q) begin
            state_q <= S_WR_ADDR;
          end else begin
            mem_addr_q  <= nxt_addr_d;
            buff_addr_q <= off_nxt_d[12:0];
            if (nxt_oor_d) begin
              buff_dout_q <= 8'h00;
              buff_wr_q   <= 1'b1;
              range_err_q <= 1'b1;
              state_q     <= S_RD_PUT;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: if (mem_ready_i) begin
          mem_rd_q    <= 1'b0;
          buff_dout_q <= mem_rdata_i;
          buff_wr_q   <= 1'b1;
          state_q     <= S_RD_PUT;
        end
        S_WR_ADDR: begin
          buff_addr_q <= offset_q[12:0];
          state_q     <= S_WR_WAIT;
        end
        S_WR_WAIT: state_q <= S_WR_SAMPLE;
        S_WR_SAMPLE: begin
          wdata_q    <= sd.sd_buff_din_i[drv_q];
          mem_addr_q <= cur_addr_d;
          if (ro_q || cur_oor_d) begin
            if (cur_oor_d) range_err_q <= 1'b1;
            offset_q <= offset_q + 14'd1;
            state_q  <= is_last_d ? S_DONE : S_WR_ADDR;
          end else begin
            mem_wr_q <= 1'b1;
            state_q  <= S_WR_REQ;
          end
        end
        S_WR_REQ: if (mem_ready_i) begin
          mem_wr_q <= 1'b0;
          offset_q <= offset_q + 14'd1;
          state_q  <= is_last_d ? S_DONE : S_WR_ADDR;
        end
        S_DONE: begin
          ack_q     <= '0;
          buff_wr_q <= 1'b0;
          mem_rd_q  <= 1'b0;
          mem_wr_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // image pulled mid-transfer: stop memory traffic, close out with DONE
      if (abort_d) begin
        mem_rd_q  <= 1'b0;
        mem_wr_q  <= 1'b0;
        buff_wr_q <= 1'b0;
        state_q   <= S_DONE;
      end
    end
  end

  assign sd.sd_ack_o       = ack_q;
  assign sd.sd_buff_addr_o = buff_addr_q;
  assign sd.sd_buff_dout_o = buff_dout_q;
  assign sd.sd_buff_wr_o   = buff_wr_q;
  assign mem_drv_o         = drv_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_rd_o          = mem_rd_q;
  assign mem_wr_o          = mem_wr_q;
  assign mem_wdata_o       = wdata_q;
  assign busy_o            = (state_q != S_IDLE);
  assign range_err_o       = range_err_q;

endmodule

// File: tb/tb_ieeedrv_sd_resp.sv
// Bench for ieeedrv_sd_resp: directed and random block transfers checked against an arithmetic byte-level model.
module tb_ieeedrv_sd_resp;
`ifdef IEEEDRV_SDRESP_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [0:0]  mem_drv;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready, busy, range_err;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  rkey;
  logic [1:0][7:0] wkey;

  int ntests = 0;
  int nfail  = 0;
  int drv_bad = 0;
  int nstrobe = 0;
  bit exp_rerr = 1'b0;
  logic [20:0] str_q[$];
  logic [31:0] mrd_q[$];
  logic [39:0] mwr_q[$];

  ieeedrv_sd_resp_if #(.SUBDRV(2)) sd_if ();

  ieeedrv_sd_resp #(.SUBDRV(2)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .sd          (sd_if),
    .mem_drv_o   (mem_drv),
    .mem_addr_o  (mem_addr),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready),
    .busy_o      (busy),
    .range_err_o (range_err)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] img_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ rkey;
  endfunction

  // drive buffer: combinational lookup of ~address, salted per drive
  always_comb begin
    for (int d = 0; d < 2; d++) sd_if.sd_buff_din_i[d] = ~sd_if.sd_buff_addr_o[7:0] ^ wkey[d];
  end

  // memory: single-cycle ready after a random wait
  always @(posedge clk_sys) begin
    if (reset) mem_ready <= 1'b0;
    else begin
      mem_ready <= (mem_rd | mem_wr) && !mem_ready && ($urandom_range(0, 3) != 0);
      mem_rdata <= img_byte(mem_addr);
    end
  end

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (sd_if.sd_buff_wr_o) begin
        str_q.push_back({sd_if.sd_buff_addr_o, sd_if.sd_buff_dout_o});
        nstrobe++;
      end
      if (mem_rd && mem_ready) mrd_q.push_back(mem_addr);
      if (mem_wr && mem_ready) mwr_q.push_back({mem_addr, mem_wdata});
      if ((mem_rd || mem_wr) && sd_if.sd_ack_o !== (2'b01 << mem_drv)) drv_bad++;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic [1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (sd_if.sd_ack_o === want) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_any_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (sd_if.sd_ack_o !== 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_xfer(input int d, input bit wr, input logic [31:0] lba, input logic [5:0] blk,
                          input bit ro, input logic [31:0] size);
    int n, ebad, eaddr, nexp;
    bit ok;
    logic [31:0] a;
    logic [12:0] k13;
    logic [7:0]  exp_d;
    bit oor;
    str_q.delete(); mrd_q.delete(); mwr_q.delete();
    @(negedge clk_sys);
    sd_if.img_readonly_i[d] = ro;
    sd_if.img_size_i[d]     = size;
    sd_if.sd_lba_i[d]       = lba;
    sd_if.sd_blk_cnt_i[d]   = blk;
    if (wr) sd_if.sd_wr_i[d] = 1'b1; else sd_if.sd_rd_i[d] = 1'b1;
    wait_any_ack(20, ok);
    check("xfer_ack", sd_if.sd_ack_o, 64'(2'b01 << d));
    wait_ack(2'b00, 40000, ok);
    check("xfer_done", ok, 1);
    sd_if.sd_rd_i[d] = 1'b0;
    sd_if.sd_wr_i[d] = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("xfer_idle", busy, 0);
    n = (int'(blk) + 1) * 256;
    ebad = 0; eaddr = 0; nexp = 0;
    for (int k = 0; k < n; k++) begin
      a   = (lba << 8) + 32'(k);
      k13 = 13'(k);
      oor = RANGE_EN && (a >= size);
      if (oor) exp_rerr = 1'b1;
      if (!wr) begin
        exp_d = oor ? 8'h00 : img_byte(a);
        if (k >= str_q.size() || str_q[k] !== {k13, exp_d}) ebad++;
        if (!oor) begin
          if (nexp >= mrd_q.size() || mrd_q[nexp] !== a) eaddr++;
          nexp++;
        end
      end else if (!oor && !ro) begin
        exp_d = ~k13[7:0] ^ wkey[d];
        if (nexp >= mwr_q.size() || mwr_q[nexp] !== {a, exp_d}) ebad++;
        nexp++;
      end
    end
    if (!wr) begin
      check("rd_strobe_cnt", str_q.size(), n);
      check("rd_strobe_data", ebad, 0);
      check("rd_mem_addr", eaddr, 0);
      check("rd_mem_cnt", mrd_q.size(), nexp);
      check("rd_no_memwr", mwr_q.size(), 0);
    end else begin
      check("wr_mem_data", ebad, 0);
      check("wr_mem_cnt", mwr_q.size(), nexp);
      check("wr_no_strobe", str_q.size(), 0);
      check("wr_no_memrd", mrd_q.size(), 0);
    end
    check("range_err", range_err, exp_rerr);
    check("mem_drv", drv_bad, 0);
  endtask

  initial begin
    bit ok;
    rkey = 8'($urandom);
    wkey[0] = 8'($urandom);
    wkey[1] = 8'($urandom);
    sd_if.img_mounted_i  = 2'b11;
    sd_if.img_readonly_i = 2'b00;
    sd_if.img_size_i     = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    sd_if.sd_lba_i       = '0;
    sd_if.sd_blk_cnt_i   = '0;
    sd_if.sd_rd_i        = 2'b00;
    sd_if.sd_wr_i        = 2'b00;
    repeat (3) @(negedge clk_sys);
    check("rst_ack", sd_if.sd_ack_o, 0);
    check("rst_busy", busy, 0);
    check("rst_memrd", mem_rd, 0);
    check("rst_memwr", mem_wr, 0);
    check("rst_buffwr", sd_if.sd_buff_wr_o, 0);
    check("rst_rangeerr", range_err, 0);
    reset = 1'b0;

    run_xfer(0, 1'b0, 32'd5, 6'd0, 1'b0, 32'hFFFF_FFFF);
    run_xfer(1, 1'b1, 32'd2, 6'd1, 1'b0, 32'hFFFF_FFFF);
    run_xfer(0, 1'b1, 32'd7, 6'd0, 1'b1, 32'hFFFF_FFFF);
    run_xfer(1, 1'b0, 32'h00FF_FFFF, 6'd1, 1'b0, 32'hFFFF_FFFF);
    for (int t = 0; t < 6; t++)
      run_xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'h000F_FFFF,
               6'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'hFFFF_FFFF);
    run_xfer(0, 1'b0, 32'd2, 6'd1, 1'b0, 32'h0000_0300);

    // simultaneous requests, then both held past DONE
    @(negedge clk_sys);
    sd_if.sd_blk_cnt_i = '0;
    sd_if.sd_rd_i = 2'b11;
    wait_any_ack(20, ok);
    check("prio_first", sd_if.sd_ack_o, 2'b01);
    wait_ack(2'b00, 20000, ok);
    check("prio_first_done", ok, 1);
    wait_any_ack(20, ok);
    check("prio_second", sd_if.sd_ack_o, 2'b10);
    wait_ack(2'b00, 20000, ok);
    check("prio_second_done", ok, 1);
    wait_any_ack(20, ok);
    check("held_no_reack", ok, 0);
    check("held_idle", busy, 0);
    sd_if.sd_rd_i = 2'b10;
    @(negedge clk_sys);
    sd_if.sd_rd_i = 2'b11;
    wait_any_ack(20, ok);
    check("rearm_ack", sd_if.sd_ack_o, 2'b01);
    wait_ack(2'b00, 20000, ok);
    sd_if.sd_rd_i = 2'b00;

    // request from an unmounted drive is ignored
    @(negedge clk_sys);
    sd_if.img_mounted_i = 2'b01;
    sd_if.sd_rd_i = 2'b10;
    wait_any_ack(20, ok);
    check("unmounted_ignored", ok, 0);
    sd_if.sd_rd_i = 2'b00;
    @(negedge clk_sys);
    sd_if.img_mounted_i = 2'b11;

    // image removed mid-transfer
    sd_if.sd_blk_cnt_i[0] = 6'd3;
    sd_if.sd_rd_i = 2'b01;
    wait_any_ack(20, ok);
    repeat (50) @(negedge clk_sys);
    sd_if.img_mounted_i = 2'b10;
    wait_ack(2'b00, 4, ok);
    check("abort_ack_drop", ok, 1);
    @(negedge clk_sys);
    check("abort_idle", busy, 0);
    sd_if.sd_rd_i = 2'b00;
    @(negedge clk_sys);
    sd_if.img_mounted_i = 2'b11;

    // reset at byte 100 of a read, request left high
    sd_if.sd_blk_cnt_i[0] = 6'd0;
    nstrobe = 0;
    sd_if.sd_rd_i = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (nstrobe >= 100) begin ok = 1'b1; break; end
    end
    check("byte100_reached", ok, 1);
    reset = 1'b1;
    exp_rerr = 1'b0;
    @(negedge clk_sys);
    check("midrst_ack", sd_if.sd_ack_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_memrd", mem_rd, 0);
    check("midrst_rangeerr", range_err, 0);
    reset = 1'b0;
    wait_any_ack(20, ok);
    check("post_rst_ack", sd_if.sd_ack_o, 2'b01);
    wait_ack(2'b00, 20000, ok);
    check("post_rst_done", ok, 1);
    sd_if.sd_rd_i = 2'b00;
    repeat (2) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
